// File: rtl/dut_pkg.sv
// Shared types and default sizing for the transaction ALU.
package dut_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ID_W_DEF   = 4;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  // Response record at the default widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ID_W_DEF-1:0]   id;
    logic                  flag;
  } resp_t;

endpackage

// File: rtl/dut_if.sv
// Request/response valid-ready bus of the transaction ALU.
//   in_*  : request channel (valid, ready, op, a, b, id)
//   out_* : response channel (valid, ready, data, id, flag)
// slave is the ALU side, master is the driver/consumer side.
interface dut_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [ID_W-1:0]   in_id;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0]   out_id;
  logic              out_flag;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_id, out_ready,
    output in_ready, out_valid, out_data, out_id, out_flag
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_id, out_ready,
    input  in_ready, out_valid, out_data, out_id, out_flag
  );
endinterface

// File: rtl/dut_sync_fifo.sv
// Synchronous FIFO, sync active-high reset.
//   wr_en/wr_data/full  : write side (write ignored when full)
//   rd_en/rd_data/empty : read side, rd_data is the head (zero when empty)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dut_wrapper.sv
// Transaction ALU: accepts (op, a, b, id) requests, computes the result in
// the accept cycle and queues {data, id, flag} responses in an output FIFO.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : request/response valid-ready bus (dut_if.slave)
//   txn_cnt  : accepted-request counter, wraps
module dut_wrapper
  import dut_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ID_W   = ID_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dut_if.slave             bus,
  output logic [CNT_W-1:0] txn_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              flag;
  } resp_word_t;

  resp_word_t alu_res;
  resp_word_t head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  always_comb begin
    alu_res    = '0;
    alu_res.id = bus.in_id;
    case (op_e'(bus.in_op))
      OP_ADD: {alu_res.flag, alu_res.data} = {1'b0, bus.in_a} + {1'b0, bus.in_b};
      OP_SUB: begin
        alu_res.data = bus.in_a - bus.in_b;
        alu_res.flag = (bus.in_a < bus.in_b);
      end
      OP_AND: begin
        alu_res.data = bus.in_a & bus.in_b;
        alu_res.flag = ~|(bus.in_a & bus.in_b);
      end
      OP_XOR: begin
        alu_res.data = bus.in_a ^ bus.in_b;
        alu_res.flag = ~|(bus.in_a ^ bus.in_b);
      end
      default: ;
    endcase
  end

  // in_ready comes only from the registered full flag, so a pop never frees
  // a slot for a push in the same cycle.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full;
  assign pop           = !empty && bus.out_ready;

  sync_fifo #(
    .WIDTH ($bits(resp_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (alu_res),
    .full    (full),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty)
  );

  assign bus.out_data = head.data;
  assign bus.out_id   = head.id;
  assign bus.out_flag = head.flag;

  always_ff @(posedge clk) begin
    if (rst)       txn_cnt <= '0;
    else if (push) txn_cnt <= txn_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_dut_wrapper.sv
module tb_dut_wrapper;
  import dut_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] txn_cnt;

  dut_if #(.DATA_W(16), .ID_W(4)) bus ();

  dut_wrapper #(.DATA_W(16), .ID_W(4), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .txn_cnt (txn_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  resp_t       q[$];
  int unsigned m_cnt = 0;

  function automatic resp_t model_alu(input logic [1:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [3:0] id);
    int unsigned ai = a;
    int unsigned bi = b;
    int unsigned r;
    bit          f;
    resp_t       res;
    case (op)
      2'd0:    begin r = ai + bi;          f = (r > 65535); end
      2'd1:    begin r = ai + 65536 - bi;  f = (ai < bi);   end
      2'd2:    begin r = ai & bi;          f = (r == 0);    end
      default: begin r = ai ^ bi;          f = (r == 0);    end
    endcase
    res.data = 16'(r % 65536);
    res.id   = id;
    res.flag = f;
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("txn_cnt", 32'(txn_cnt), m_cnt);
    if (q.size() > 0) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].data));
      chk("out_id", 32'(bus.out_id), 32'(q[0].id));
      chk("out_flag", 32'(bus.out_flag), 32'(q[0].flag));
    end
  endtask

  // One clock: inputs already applied; model follows the edge, then check.
  task automatic do_cycle();
    bit do_push;
    bit do_pop;
    resp_t r;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      do_push = bus.in_valid && (q.size() < DEPTH);
      do_pop  = bus.out_ready && (q.size() > 0);
      r = model_alu(bus.in_op, bus.in_a, bus.in_b, bus.in_id);
      if (do_pop)  void'(q.pop_front());
      if (do_push) begin
        q.push_back(r);
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic iv, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] id, input logic ordy);
    bus.in_valid  = iv;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_id     = id;
    bus.out_ready = ordy;
    do_cycle();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 2'd0, 16'h0, 16'h0, 4'h0, ordy);
  endtask

  initial begin
    int unsigned n;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_id     = '0;
    bus.out_ready = 1'b0;

    // Reset held two cycles.
    rst = 1'b1;
    idle(1'b1);
    idle(1'b1);
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_id", 32'(bus.out_id), 32'd0);
    chk("rst_out_flag", 32'(bus.out_flag), 32'd0);

    // ADD wrap with carry.
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 4'd3, 1'b1);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_data", 32'(bus.out_data), 32'h0000);
    chk("add_flag", 32'(bus.out_flag), 32'd1);
    chk("add_id", 32'(bus.out_id), 32'd3);
    idle(1'b1);
    chk("add_drained", 32'(bus.out_valid), 32'd0);

    // SUB borrow, AND zero, XOR zero, in order.
    drive(1'b1, OP_SUB, 16'd5, 16'd7, 4'd1, 1'b0);
    drive(1'b1, OP_AND, 16'h00F0, 16'h0F00, 4'd2, 1'b0);
    drive(1'b1, OP_XOR, 16'h1234, 16'h1234, 4'd3, 1'b0);
    chk("sub_data", 32'(bus.out_data), 32'hFFFE);
    chk("sub_flag", 32'(bus.out_flag), 32'd1);
    chk("sub_id", 32'(bus.out_id), 32'd1);
    idle(1'b1);
    chk("and_data", 32'(bus.out_data), 32'h0000);
    chk("and_flag", 32'(bus.out_flag), 32'd1);
    chk("and_id", 32'(bus.out_id), 32'd2);
    idle(1'b1);
    chk("xor_data", 32'(bus.out_data), 32'h0000);
    chk("xor_flag", 32'(bus.out_flag), 32'd1);
    chk("xor_id", 32'(bus.out_id), 32'd3);
    idle(1'b1);

    // Backpressure: fill, hold a fifth request, single pop, drain.
    for (int i = 0; i < 4; i++)
      drive(1'b1, OP_ADD, 16'(i), 16'(i), 4'(i), 1'b0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, OP_ADD, 16'd4, 16'd4, 4'd4, 1'b0);
    chk("held_in_ready", 32'(bus.in_ready), 32'd0);
    chk("held_txn_cnt", 32'(txn_cnt), 32'd8);
    chk("held_head_id", 32'(bus.out_id), 32'd0);
    drive(1'b1, OP_ADD, 16'd4, 16'd4, 4'd4, 1'b1);
    chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("no_bypass_txn_cnt", 32'(txn_cnt), 32'd8);
    drive(1'b1, OP_ADD, 16'd4, 16'd4, 4'd4, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_id", 32'(bus.out_id), 32'(i));
      chk("drain_data", 32'(bus.out_data), 32'(2 * i));
      idle(1'b1);
    end
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // Simultaneous push/pop at occupancy 2.
    drive(1'b1, OP_XOR, 16'h1111, 16'h2222, 4'd5, 1'b0);
    drive(1'b1, OP_XOR, 16'h3333, 16'h4444, 4'd6, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(1'b1, OP_XOR, 16'($urandom), 16'($urandom), 4'(7 + i), 1'b1);
    n = 0;
    for (int i = 0; i < 8 && bus.out_valid; i++) begin
      n++;
      idle(1'b1);
    end
    chk("steady_occupancy", n, 32'd2);

    // Reset with three queued and a request in flight.
    for (int i = 0; i < 3; i++)
      drive(1'b1, OP_SUB, 16'(i), 16'd1, 4'(i + 9), 1'b0);
    rst = 1'b1;
    drive(1'b1, OP_ADD, 16'd1, 16'd1, 4'd15, 1'b1);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    idle(1'b1);
    idle(1'b0);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 9) < 6), 2'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 1'($urandom_range(0, 9) < 5));

    n = 0;
    while (bus.out_valid && n < 20) begin
      n++;
      idle(1'b1);
    end
    chk("final_drain", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
